// File: rtl/esl_nios_ii_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug memory engine.
// Holds FSM encodings, jdo field positions, the JTAG op kinds and the out-of-range read pattern.
package esl_nios_ii_dbg_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_JREQ  = 3'd1;
  localparam logic [2:0] ST_JRESP = 3'd2;
  localparam logic [2:0] ST_JWR   = 3'd3;
  localparam logic [2:0] ST_AREAD = 3'd4;

  localparam int JDO_W          = 38;
  localparam int JDO_AUTORD_BIT = 1;
  localparam int JDO_ADDR_LSB   = 2;
  localparam int JDO_DATA_W     = 32;

  localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    JOP_NONE = 2'd0,
    JOP_A    = 2'd1,
    JOP_NA   = 2'd2,
    JOP_B    = 2'd3
  } jop_e;

  // One JTAG request; dat carries jdo[31:0], which holds address, auto_read and write data.
  typedef struct packed {
    jop_e                  op;
    logic [JDO_DATA_W-1:0] dat;
  } jreq_t;

  function automatic jop_e jop_pick(input logic take_b, input logic take_a, input logic take_na);
    if (take_b)  return JOP_B;
    if (take_a)  return JOP_A;
    if (take_na) return JOP_NA;
    return JOP_NONE;
  endfunction

endpackage

// File: rtl/esl_nios_ii_dbg_ram.sv
// Single-port DEPTH x 32 debug RAM with byte-lane writes and a registered read port.
// Read data appears one cycle after an enabled read; no backpressure, the caller owns arbitration.
module esl_nios_ii_dbg_ram #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/esl_nios_ii_cpu_jtag_ocimem.sv
// JTAG debug memory engine: arbitrates the debug RAM between JTAG monitor ops and a CPU Avalon-MM slave.
// JTAG read 2 cycles, JTAG write 1 cycle, CPU read 1 wait cycle; CPU stalls via waitrequest while JTAG owns the RAM.
module esl_nios_ii_cpu_jtag_ocimem
  import esl_nios_ii_dbg_pkg::*;
#(
  parameter int AW   = 6,
  parameter int JA_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [JDO_W-1:0] jdo,
  input  logic             take_action_ocimem_a,
  input  logic             take_no_action_ocimem_a,
  input  logic             take_action_ocimem_b,
  input  logic [AW-1:0]    avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic [3:0]       avs_byteenable,
  output logic [31:0]      avs_readdata,
  output logic             avs_waitrequest,
  output logic [31:0]      MonDReg,
  output logic             monitor_ready,
  output logic             monitor_error
);

  logic [2:0]      state_q, state_d;
  logic [JA_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]     mon_d_q, mon_d_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     wdat_q, wdat_d;
  jreq_t           pend_q, pend_d;

  jreq_t           fresh;
  jreq_t           cur;
  logic [JA_W-1:0] cur_addr;
  logic [JA_W-1:0] inc_addr;
  logic            any_take;
  logic            cpu_strobe;

  logic            ram_en;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_addr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_q;

  logic            unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_DATA_W], jdo[0]};

  function automatic logic in_range(input logic [JA_W-1:0] a);
    return a[JA_W-1:AW] == '0;
  endfunction

  assign fresh.op   = jop_pick(take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a);
  assign fresh.dat  = jdo[JDO_DATA_W-1:0];
  // A request parked during a CPU read goes ahead of anything arriving now.
  assign cur        = (pend_q.op != JOP_NONE) ? pend_q : fresh;
  assign cur_addr   = cur.dat[JDO_ADDR_LSB +: JA_W];
  assign inc_addr   = mon_a_q + JA_W'(1);
  assign any_take   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign cpu_strobe = avs_read | avs_write;

  always_comb begin
    state_d         = state_q;
    mon_a_d         = mon_a_q;
    mon_d_d         = mon_d_q;
    err_d           = err_q;
    rdata_d         = rdata_q;
    wdat_d          = wdat_q;
    pend_d          = pend_q;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_be          = 4'h0;
    ram_addr        = mon_a_q[AW-1:0];
    ram_wdata       = wdat_q;
    avs_waitrequest = 1'b0;
    avs_readdata    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        pend_d = '0;
        if (cur.op != JOP_NONE) avs_waitrequest = cpu_strobe;
        case (cur.op)
          JOP_A: begin
            mon_a_d = cur_addr;
            if (!in_range(cur_addr)) begin
              err_d = 1'b1;
              if (cur.dat[JDO_AUTORD_BIT]) mon_d_d = ERR_PATTERN;
            end else begin
              err_d = 1'b0;
              if (cur.dat[JDO_AUTORD_BIT]) state_d = ST_JREQ;
            end
          end
          JOP_NA: begin
            mon_a_d = inc_addr;
            if (in_range(inc_addr)) begin
              state_d = ST_JREQ;
            end else begin
              mon_d_d = ERR_PATTERN;
              err_d   = 1'b1;
            end
          end
          JOP_B: begin
            if (in_range(mon_a_q)) begin
              wdat_d  = cur.dat;
              state_d = ST_JWR;
            end else begin
              mon_a_d = inc_addr;
              mon_d_d = ERR_PATTERN;
              err_d   = 1'b1;
            end
          end
          default: begin
            if (avs_write) begin
              ram_en    = 1'b1;
              ram_we    = 1'b1;
              ram_be    = avs_byteenable;
              ram_addr  = avs_address;
              ram_wdata = avs_writedata;
            end else if (avs_read) begin
              ram_en          = 1'b1;
              ram_addr        = avs_address;
              avs_waitrequest = 1'b1;
              state_d         = ST_AREAD;
            end
          end
        endcase
      end
      ST_JREQ: begin
        ram_en          = 1'b1;
        avs_waitrequest = cpu_strobe;
        if (any_take) err_d = 1'b1;
        state_d = ST_JRESP;
      end
      ST_JRESP: begin
        mon_d_d         = ram_q;
        avs_waitrequest = cpu_strobe;
        if (any_take) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_JWR: begin
        ram_en          = 1'b1;
        ram_we          = 1'b1;
        ram_be          = 4'hF;
        mon_a_d         = inc_addr;
        avs_waitrequest = cpu_strobe;
        if (any_take) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_AREAD: begin
        avs_readdata = ram_q;
        rdata_d      = ram_q;
        // The monitor is still ready here, so a pulse is parked instead of flagged.
        if (fresh.op != JOP_NONE) pend_d = fresh;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = !((state_d == ST_JREQ) || (state_d == ST_JRESP) || (state_d == ST_JWR));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdat_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      mon_d_q <= mon_d_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdat_q  <= wdat_d;
      pend_q  <= pend_d;
    end
  end

  esl_nios_ii_dbg_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en & ~reset),
    .we    (ram_we & ~reset),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_esl_nios_ii_cpu_jtag_ocimem.sv
// Directed bench for the JTAG debug memory engine with scoreboard queues for MonDReg and avs_readdata.
module tb_esl_nios_ii_cpu_jtag_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [5:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  esl_nios_ii_cpu_jtag_ocimem #(.AW(6), .JA_W(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] jexp_q[$];
  logic [31:0] cexp_q[$];
  logic [31:0] mem_m [64];
  logic [15:0] ma;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
    avs_read                = 1'b0;
    avs_write               = 1'b0;
  endtask

  function automatic logic [37:0] mk_a(input logic [15:0] a, input logic rd);
    logic [37:0] v;
    v       = '0;
    v[17:2] = a;
    v[1]    = rd;
    return v;
  endfunction

  task automatic pulse_a(input logic [15:0] a, input logic rd);
    tick(); clr();
    jdo = mk_a(a, rd);
    take_action_ocimem_a = 1'b1;
    ma = a;
    settle();
  endtask

  task automatic pulse_na();
    tick(); clr();
    take_no_action_ocimem_a = 1'b1;
    ma = ma + 16'd1;
    settle();
  endtask

  task automatic pulse_b(input logic [31:0] d);
    tick(); clr();
    jdo = {6'b0, d};
    take_action_ocimem_b = 1'b1;
    if (ma < 16'd64) mem_m[ma[5:0]] = d;
    ma = ma + 16'd1;
    settle();
  endtask

  // Runs until monitor_ready has dropped and risen again.
  task automatic jwait(input string tag);
    bit seen_low = 1'b0;
    bit done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); clr(); settle();
      if (!monitor_ready) seen_low = 1'b1;
      else if (seen_low) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic jread_check(input string tag);
    jwait(tag);
    chk(tag, MonDReg, jexp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [5:0] a, input logic [31:0] d);
    tick(); clr();
    avs_write = 1'b1; avs_address = a; avs_writedata = d; avs_byteenable = 4'hF;
    mem_m[a] = d;
    settle();
    chk("cpu_wr_accept", 32'(avs_waitrequest), 32'd0);
  endtask

  task automatic cpu_read(input logic [5:0] a, input string tag, output int waits);
    bit done = 1'b0;
    tick(); clr();
    avs_read = 1'b1; avs_address = a;
    cexp_q.push_back(mem_m[a]);
    settle();
    waits = 0;
    for (int k = 0; k < 8; k++) begin
      if (!avs_waitrequest) begin
        done = 1'b1;
        break;
      end
      waits++;
      tick(); settle();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk(tag, avs_readdata, cexp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clr();
    reset = 1'b1; jdo = '0; avs_address = '0; avs_writedata = '0; avs_byteenable = 4'hF; ma = '0;
    repeat (3) tick();
    tick(); settle();
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'd0);
    reset = 1'b0;

    // JTAG auto-read of a CPU-written word: ready low for exactly two cycles.
    cpu_write(6'd5, 32'h1234_5678);
    pulse_a(16'd5, 1'b1);
    jexp_q.push_back(mem_m[5]);
    chk("t1_ready_n", 32'(monitor_ready), 32'd1);
    tick(); clr(); settle();
    chk("t1_ready_n1", 32'(monitor_ready), 32'd0);
    tick(); settle();
    chk("t1_ready_n2", 32'(monitor_ready), 32'd0);
    tick(); settle();
    chk("t1_ready_n3", 32'(monitor_ready), 32'd1);
    chk("t1_mondreg", MonDReg, jexp_q.pop_front());

    // Address load without read, then streamed JTAG writes.
    pulse_a(16'd0, 1'b0);
    tick(); clr(); settle();
    chk("t2_noread_ready", 32'(monitor_ready), 32'd1);
    chk("t2_noread_err", 32'(monitor_error), 32'd0);
    pulse_b(32'hAAAA_0001);
    tick(); clr(); settle();
    chk("t2_jwr_ready", 32'(monitor_ready), 32'd0);
    tick(); settle();
    chk("t2_jwr_done", 32'(monitor_ready), 32'd1);
    pulse_b(32'hBBBB_0002); jwait("t2_wr_b");
    pulse_b(32'hCCCC_0003); jwait("t2_wr_c");
    pulse_b(32'hDDDD_0004); jwait("t2_wr_d");
    cpu_read(6'd0, "t2_rd0", w);
    chk("t2_rd_waits", 32'(w), 32'd1);
    cpu_read(6'd1, "t2_rd1", w);
    cpu_read(6'd2, "t2_rd2", w);
    cpu_read(6'd3, "t2_rd3_mona", w);

    // Out-of-range read, then in-range load clears the error.
    pulse_a(16'd64, 1'b1);
    tick(); clr(); settle();
    chk("t3_oor_ready", 32'(monitor_ready), 32'd1);
    chk("t3_oor_mondreg", MonDReg, 32'hDEAD_BEEF);
    chk("t3_oor_err", 32'(monitor_error), 32'd1);
    pulse_a(16'd1, 1'b0);
    tick(); clr(); settle();
    chk("t3_err_clear", 32'(monitor_error), 32'd0);
    pulse_na(); jexp_q.push_back(mem_m[2]);
    jread_check("t3_na_read");
    pulse_a(16'd62, 1'b0);
    pulse_b(32'hEEEE_0062); jwait("t3_wr_62");
    pulse_na();
    tick(); clr(); settle();
    chk("t3_na_oor_mondreg", MonDReg, 32'hDEAD_BEEF);
    chk("t3_na_oor_err", 32'(monitor_error), 32'd1);
    cpu_read(6'd62, "t3_rd62", w);

    // CPU read collides with a JTAG write to the same word.
    pulse_a(16'd4, 1'b0);
    cpu_write(6'd4, 32'h4444_4444);
    tick(); clr();
    jdo = {6'b0, 32'h6060_0004};
    take_action_ocimem_b = 1'b1;
    avs_read = 1'b1; avs_address = 6'd4;
    mem_m[4] = 32'h6060_0004; ma = 16'd5;
    cexp_q.push_back(mem_m[4]);
    settle();
    chk("t4_wait_n", 32'(avs_waitrequest), 32'd1);
    tick(); take_action_ocimem_b = 1'b0; settle();
    chk("t4_wait_n1", 32'(avs_waitrequest), 32'd1);
    begin
      bit done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        tick(); settle();
        if (!avs_waitrequest) begin
          done = 1'b1;
          break;
        end
      end
      chk("t4_rd_done", 32'(done), 32'd1);
      chk("t4_post_write_data", avs_readdata, cexp_q.pop_front());
    end

    // Pulse while a JTAG read is in flight is an overrun and is ignored.
    pulse_a(16'd1, 1'b1); jexp_q.push_back(mem_m[1]);
    tick(); clr(); take_no_action_ocimem_a = 1'b1; settle();
    chk("t5_busy", 32'(monitor_ready), 32'd0);
    jread_check("t5_read_b");
    chk("t5_overrun_err", 32'(monitor_error), 32'd1);
    pulse_na(); jexp_q.push_back(mem_m[2]);
    jread_check("t5_mona_unchanged");
    chk("t5_err_sticky", 32'(monitor_error), 32'd1);

    // Pulse during the CPU read data cycle is parked, not an overrun.
    pulse_a(16'd0, 1'b0);
    tick(); clr();
    avs_read = 1'b1; avs_address = 6'd1;
    cexp_q.push_back(mem_m[1]);
    settle();
    chk("t6_aread_wait", 32'(avs_waitrequest), 32'd1);
    tick();
    jdo = mk_a(16'd3, 1'b1); take_action_ocimem_a = 1'b1; ma = 16'd3;
    jexp_q.push_back(mem_m[3]);
    settle();
    chk("t6_aread_done", 32'(avs_waitrequest), 32'd0);
    chk("t6_aread_data", avs_readdata, cexp_q.pop_front());
    jread_check("t6_pending_read");
    chk("t6_no_overrun", 32'(monitor_error), 32'd0);

    // Simultaneous pulses: ocimem_b beats ocimem_a beats no_action.
    tick(); clr();
    jdo = {6'b0, 32'hCAFE_0042};
    take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
    mem_m[3] = 32'hCAFE_0042; ma = 16'd4;
    settle();
    jwait("t7_prio_b");
    chk("t7_prio_err", 32'(monitor_error), 32'd0);
    cpu_read(6'd3, "t7_prio_b_data", w);
    tick(); clr();
    jdo = mk_a(16'd0, 1'b1);
    take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1;
    ma = 16'd0; jexp_q.push_back(mem_m[0]);
    settle();
    jread_check("t7_prio_a");

    // Address wrap keeps the error sticky; then reset lands in JREQ.
    pulse_a(16'hFFFF, 1'b0);
    pulse_na(); jexp_q.push_back(mem_m[0]);
    jread_check("t8_wrap_read");
    chk("t8_wrap_sticky", 32'(monitor_error), 32'd1);
    pulse_na();
    tick(); clr(); reset = 1'b1; settle();
    chk("t8_in_jreq", 32'(monitor_ready), 32'd0);
    tick(); settle();
    chk("t8_rst_mondreg", MonDReg, 32'h0);
    chk("t8_rst_ready", 32'(monitor_ready), 32'd1);
    chk("t8_rst_error", 32'(monitor_error), 32'd0);
    chk("t8_rst_readdata", avs_readdata, 32'h0);
    chk("t8_rst_waitreq", 32'(avs_waitrequest), 32'd0);
    reset = 1'b0;
    cpu_read(6'd0, "t8_ram0", w);
    cpu_read(6'd1, "t8_ram1", w);
    cpu_read(6'd2, "t8_ram2", w);

    tick(); clr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
